// File: rtl/dual_port_ram_arbiter_if.sv
// Requester-side and RAM-side signals of the two-master RAM arbiter.
// Combinational acks; a requester holds its command until acked.
interface dual_port_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_req_0,  wr_req_1;
    logic [ADDR_WIDTH-1:0] wr_addr_0, wr_addr_1;
    logic [DATA_WIDTH-1:0] wr_data_0, wr_data_1;
    logic                  wr_ack_0,  wr_ack_1;
    logic                  rd_req_0,  rd_req_1;
    logic [ADDR_WIDTH-1:0] rd_addr_0, rd_addr_1;
    logic                  rd_ack_0,  rd_ack_1;
    logic                  rd_valid_0, rd_valid_1;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  wr_req_0, wr_req_1, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        input  rd_req_0, rd_req_1, rd_addr_0, rd_addr_1, ram_dout,
        output wr_ack_0, wr_ack_1, rd_ack_0, rd_ack_1, rd_valid_0, rd_valid_1,
        output rd_data, ram_waddr, ram_din, ram_we, ram_raddr
    );

    modport master (
        output wr_req_0, wr_req_1, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        output rd_req_0, rd_req_1, rd_addr_0, rd_addr_1, ram_dout,
        input  wr_ack_0, wr_ack_1, rd_ack_0, rd_ack_1, rd_valid_0, rd_valid_1,
        input  rd_data, ram_waddr, ram_din, ram_we, ram_raddr
    );
endinterface

// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbitration of two masters onto one dual-port RAM, write and read channels independent.
// Latency: ack same cycle, read data one cycle after ack; backpressure: a loser simply sees no ack.
module dual_port_ram_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    dual_port_ram_arbiter_if.slave  bus
);
    logic                  wr_last_q, wr_last_d;
    logic                  wr_sel_q,  wr_sel_d;
    logic                  rd_last_q, rd_last_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_vld0_q, rd_vld0_d;
    logic                  rd_vld1_q, rd_vld1_d;

    logic                  wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1;
    logic                  wr_mux_sel;
    logic [DATA_WIDTH-1:0] wr_din;

    always_comb begin
        // On contention the requester that did not win last time gets the grant.
        wr_gnt_0 = reset_n && bus.wr_req_0 && (!bus.wr_req_1 ||  wr_last_q);
        wr_gnt_1 = reset_n && bus.wr_req_1 && (!bus.wr_req_0 || !wr_last_q);
        rd_gnt_0 = reset_n && bus.rd_req_0 && (!bus.rd_req_1 ||  rd_last_q);
        rd_gnt_1 = reset_n && bus.rd_req_1 && (!bus.rd_req_0 || !rd_last_q);

        wr_last_d = wr_last_q;
        wr_sel_d  = wr_sel_q;
        if (wr_gnt_0) begin
            wr_last_d = 1'b0;
            wr_sel_d  = 1'b0;
        end else if (wr_gnt_1) begin
            wr_last_d = 1'b1;
            wr_sel_d  = 1'b1;
        end

        rd_last_d = rd_last_q;
        rd_addr_d = rd_addr_q;
        if (rd_gnt_0) begin
            rd_last_d = 1'b0;
            rd_addr_d = bus.rd_addr_0;
        end else if (rd_gnt_1) begin
            rd_last_d = 1'b1;
            rd_addr_d = bus.rd_addr_1;
        end

        rd_vld0_d = rd_gnt_0;
        rd_vld1_d = rd_gnt_1;

        // Idle write port keeps steering the last winner's fields.
        wr_mux_sel = (wr_gnt_0 || wr_gnt_1) ? wr_gnt_1 : wr_sel_q;
        wr_din     = wr_mux_sel ? bus.wr_data_1 : bus.wr_data_0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_last_q <= 1'b1;
            rd_last_q <= 1'b1;
            wr_sel_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_vld0_q <= 1'b0;
            rd_vld1_q <= 1'b0;
        end else begin
            wr_last_q <= wr_last_d;
            rd_last_q <= rd_last_d;
            wr_sel_q  <= wr_sel_d;
            rd_addr_q <= rd_addr_d;
            rd_vld0_q <= rd_vld0_d;
            rd_vld1_q <= rd_vld1_d;
        end
    end

    assign bus.wr_ack_0  = wr_gnt_0;
    assign bus.wr_ack_1  = wr_gnt_1;
    assign bus.rd_ack_0  = rd_gnt_0;
    assign bus.rd_ack_1  = rd_gnt_1;
    assign bus.ram_we    = wr_gnt_0 || wr_gnt_1;
    assign bus.ram_waddr = wr_mux_sel ? bus.wr_addr_1 : bus.wr_addr_0;
    assign bus.ram_din   = wr_din;
    // Unchanged read address keeps rd_data stable between reads.
    assign bus.ram_raddr = rd_addr_d;
    assign bus.rd_data   = bus.ram_dout;
    // A reset arriving while a read is in flight suppresses its delivery.
    assign bus.rd_valid_0 = rd_vld0_q && reset_n;
    assign bus.rd_valid_1 = rd_vld1_q && reset_n;
endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed bench for dual_port_ram_arbiter with a write-first RAM model and a read scoreboard.
module tb_dual_port_ram_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dual_port_ram_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    dual_port_ram_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM model: registered read address, write-first.
    logic [31:0] ram_mem [32];
    logic [4:0]  ram_raddr_r;
    logic        pre_en;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) ram_mem[pre_addr] <= pre_data;
        else if (bus.ram_we) ram_mem[bus.ram_waddr] <= bus.ram_din;
        ram_raddr_r <= bus.ram_raddr;
    end
    assign bus.ram_dout = ram_mem[ram_raddr_r];

    typedef struct { bit who; logic [31:0] data; } rd_exp_t;
    rd_exp_t     pend[$];
    logic [31:0] shadow [32];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_acks(input string tag, input bit w0, input bit w1, input bit r0, input bit r1);
        check({tag, "_wr_ack_0"}, 32'(bus.wr_ack_0), 32'(w0));
        check({tag, "_wr_ack_1"}, 32'(bus.wr_ack_1), 32'(w1));
        check({tag, "_rd_ack_0"}, 32'(bus.rd_ack_0), 32'(r0));
        check({tag, "_rd_ack_1"}, 32'(bus.rd_ack_1), 32'(r1));
    endtask

    // Called once per cycle, mid-cycle: retire last cycle's read, then record this cycle's commands.
    task automatic sb_cycle();
        rd_exp_t e;
        if (!reset_n) begin
            check("rst_rd_valid_0", 32'(bus.rd_valid_0), 32'd0);
            check("rst_rd_valid_1", 32'(bus.rd_valid_1), 32'd0);
            pend.delete();
        end else if (pend.size() > 0) begin
            e = pend.pop_front();
            check("sb_rd_valid_0", 32'(bus.rd_valid_0), 32'(e.who == 1'b0));
            check("sb_rd_valid_1", 32'(bus.rd_valid_1), 32'(e.who == 1'b1));
            check("sb_rd_data", bus.rd_data, e.data);
        end else begin
            check("idle_rd_valid_0", 32'(bus.rd_valid_0), 32'd0);
            check("idle_rd_valid_1", 32'(bus.rd_valid_1), 32'd0);
        end
        if (bus.wr_ack_0 && bus.wr_ack_1) check("wr_ack_overlap", 32'd1, 32'd0);
        if (bus.rd_ack_0 && bus.rd_ack_1) check("rd_ack_overlap", 32'd1, 32'd0);
        if (bus.wr_ack_0) shadow[bus.wr_addr_0] = bus.wr_data_0;
        if (bus.wr_ack_1) shadow[bus.wr_addr_1] = bus.wr_data_1;
        if (bus.rd_ack_0) pend.push_back('{1'b0, shadow[bus.rd_addr_0]});
        if (bus.rd_ack_1) pend.push_back('{1'b1, shadow[bus.rd_addr_1]});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        sb_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        bit [3:0] wr_pat;
        bit       winner;

        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        reset_n = 1'b0;
        bus.wr_req_0 = 1'b1; bus.wr_req_1 = 1'b0; bus.rd_req_0 = 1'b0; bus.rd_req_1 = 1'b1;
        bus.wr_addr_0 = 5'd9; bus.wr_addr_1 = 5'd0; bus.wr_data_0 = 32'h9; bus.wr_data_1 = 32'h0;
        bus.rd_addr_0 = 5'd0; bus.rd_addr_1 = 5'd4;
        pre_en = 1'b1; pre_addr = 5'd5; pre_data = 32'h55;
        shadow[5] = 32'h55;
        shadow[6] = 32'h66;

        // Reset with requests pending: nothing may be acked or written.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sb_cycle();
            chk_acks("reset", 0, 0, 0, 0);
            check("reset_ram_we", 32'(bus.ram_we), 32'd0);
            next_cycle();
            if (i == 0) begin pre_addr = 5'd6; pre_data = 32'h66; end
            else pre_en = 1'b0;
        end
        bus.wr_req_0 = 1'b0; bus.rd_req_1 = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sb_cycle();
            chk_acks("idle", 0, 0, 0, 0);
            check("idle_ram_we", 32'(bus.ram_we), 32'd0);
            next_cycle();
        end

        // Write contention from reset: grants alternate 0,1,0,1.
        do_reset();
        bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 5'd1; bus.wr_data_0 = 32'hA0;
        bus.wr_req_1 = 1'b1; bus.wr_addr_1 = 5'd2; bus.wr_data_1 = 32'hB0;
        wr_pat = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            winner = wr_pat[i];
            @(negedge clk);
            sb_cycle();
            chk_acks("wr_cont", !winner, winner, 0, 0);
            check("wr_cont_we", 32'(bus.ram_we), 32'd1);
            check("wr_cont_waddr", 32'(bus.ram_waddr), winner ? 32'd2 : 32'd1);
            check("wr_cont_din", bus.ram_din, winner ? bus.wr_data_1 : bus.wr_data_0);
            next_cycle();
            if (winner) bus.wr_data_1 = bus.wr_data_1 + 32'd1;
            else        bus.wr_data_0 = bus.wr_data_0 + 32'd1;
        end
        bus.wr_req_0 = 1'b0; bus.wr_req_1 = 1'b0;
        @(negedge clk);
        sb_cycle();
        check("wr_idle_we", 32'(bus.ram_we), 32'd0);
        check("wr_idle_waddr_hold", 32'(bus.ram_waddr), 32'd2);
        next_cycle();

        // Single write then read-back.
        bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 5'd3; bus.wr_data_0 = 32'hDEADBEEF;
        @(negedge clk);
        sb_cycle();
        chk_acks("single_wr", 1, 0, 0, 0);
        check("single_wr_we", 32'(bus.ram_we), 32'd1);
        check("single_wr_waddr", 32'(bus.ram_waddr), 32'd3);
        check("single_wr_din", bus.ram_din, 32'hDEADBEEF);
        next_cycle();
        bus.wr_req_0 = 1'b0;
        bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 5'd3;
        @(negedge clk);
        sb_cycle();
        chk_acks("single_rd", 0, 0, 1, 0);
        check("single_rd_raddr", 32'(bus.ram_raddr), 32'd3);
        next_cycle();
        bus.rd_req_0 = 1'b0;
        @(negedge clk);
        sb_cycle();
        check("single_rd_valid_0", 32'(bus.rd_valid_0), 32'd1);
        check("single_rd_data", bus.rd_data, 32'hDEADBEEF);
        next_cycle();

        // Read contention from reset: requester 0 first, then 1, with tagged data.
        do_reset();
        bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 5'd5;
        bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 5'd6;
        @(negedge clk);
        sb_cycle();
        chk_acks("rd_cont_a", 0, 0, 1, 0);
        next_cycle();
        bus.rd_req_0 = 1'b0;
        @(negedge clk);
        sb_cycle();
        chk_acks("rd_cont_b", 0, 0, 0, 1);
        check("rd_cont_valid_0", 32'(bus.rd_valid_0), 32'd1);
        check("rd_cont_data_55", bus.rd_data, 32'h55);
        next_cycle();
        bus.rd_req_1 = 1'b0;
        @(negedge clk);
        sb_cycle();
        check("rd_cont_valid_1", 32'(bus.rd_valid_1), 32'd1);
        check("rd_cont_valid_0_off", 32'(bus.rd_valid_0), 32'd0);
        check("rd_cont_data_66", bus.rd_data, 32'h66);
        next_cycle();

        // Same-cycle write and read to one address: read sees the new data.
        bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 5'd7; bus.wr_data_0 = 32'h1234;
        bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 5'd7;
        @(negedge clk);
        sb_cycle();
        chk_acks("wr_rd_same", 1, 0, 0, 1);
        next_cycle();
        bus.wr_req_0 = 1'b0; bus.rd_req_1 = 1'b0;
        @(negedge clk);
        sb_cycle();
        check("wr_rd_same_valid_1", 32'(bus.rd_valid_1), 32'd1);
        check("wr_rd_same_data", bus.rd_data, 32'h1234);
        check("raddr_hold", 32'(bus.ram_raddr), 32'd7);
        check("idle_we_after", 32'(bus.ram_we), 32'd0);
        next_cycle();

        // Reset right after a read ack drops the pending valid and rewinds round-robin.
        bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 5'd6;
        @(negedge clk);
        sb_cycle();
        chk_acks("mid_rst_rd", 0, 0, 0, 1);
        next_cycle();
        bus.rd_req_1 = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        sb_cycle();
        check("mid_rst_valid_1", 32'(bus.rd_valid_1), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 5'd5; bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 5'd6;
        bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 5'd1; bus.wr_req_1 = 1'b1; bus.wr_addr_1 = 5'd2;
        @(negedge clk);
        sb_cycle();
        chk_acks("post_rst_cont", 1, 0, 1, 0);
        next_cycle();
        bus.rd_req_0 = 1'b0; bus.rd_req_1 = 1'b0; bus.wr_req_0 = 1'b0; bus.wr_req_1 = 1'b0;
        @(negedge clk);
        sb_cycle();
        next_cycle();
        check("sb_drained", 32'(pend.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
